// File: rtl/adc_capture_buffer_if.sv
// adc_capture_buffer_if: control, sample, read-port and status bundle for adc_capture_buffer
//   sample/sample_valid: ADC result and its one-cycle strobe
//   start/stop/mode: arm a capture, end a continuous capture, 0 single-shot / 1 continuous
//   rd_en/rd_addr -> rd_data/rd_valid: registered random-access read, addr 0 = newest
//   storage/count/busy/done/full: flat store (newest in low word) and capture status
interface adc_capture_buffer_if #(
    parameter int SAMPLE_W = 12,
    parameter int DEPTH    = 10
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic [SAMPLE_W-1:0]       sample;
    logic                      sample_valid;
    logic                      start;
    logic                      stop;
    logic                      mode;
    logic                      rd_en;
    logic [CNT_W-1:0]          rd_addr;
    logic [SAMPLE_W-1:0]       rd_data;
    logic                      rd_valid;
    logic [DEPTH*SAMPLE_W-1:0] storage;
    logic [CNT_W-1:0]          count;
    logic                      busy;
    logic                      done;
    logic                      full;
    modport master (
        output sample, sample_valid, start, stop, mode, rd_en, rd_addr,
        input  rd_data, rd_valid, storage, count, busy, done, full
    );
    modport slave (
        input  sample, sample_valid, start, stop, mode, rd_en, rd_addr,
        output rd_data, rd_valid, storage, count, busy, done, full
    );
endinterface

// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: start/stop controlled shift-register capture of ADC samples with registered read port
//   clk: rising-edge system clock; rst: asynchronous active-low reset
//   bus: adc_capture_buffer_if.slave carrying samples, control, read port and status
module adc_capture_buffer #(
    parameter int SAMPLE_W = 12,
    parameter int DEPTH    = 10
) (
    input logic                 clk,
    input logic                 rst,
    adc_capture_buffer_if.slave bus
);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int STORE_W = DEPTH * SAMPLE_W;
    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;
    state_t              state;
    logic [STORE_W-1:0]  storage;
    logic [STORE_W-1:0]  rd_shift;
    logic [CNT_W-1:0]    count;
    logic [CNT_W-1:0]    count_inc;
    logic [SAMPLE_W-1:0] rd_data;
    logic [SAMPLE_W-1:0] rd_word;
    logic                rd_valid;
    logic                busy;
    logic                done;
    logic                mode_q;
    logic                last;
    always_comb begin
        count_inc = (count == CNT_W'(DEPTH)) ? count : count + CNT_W'(1);
        rd_shift  = storage >> (32'(bus.rd_addr) * SAMPLE_W);
        rd_word   = (bus.rd_addr < CNT_W'(DEPTH)) ? rd_shift[SAMPLE_W-1:0] : '0;
        // single-shot ends on the sample that fills the store; continuous ends only on stop
        last      = mode_q ? bus.stop : (bus.sample_valid && count_inc == CNT_W'(DEPTH));
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            storage  <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mode_q   <= 1'b0;
        end else begin
            rd_valid <= bus.rd_en;
            if (bus.rd_en)
                rd_data <= rd_word;
            if (state == CAPTURE) begin
                if (bus.sample_valid) begin
                    storage <= {storage[STORE_W-SAMPLE_W-1:0], bus.sample};
                    count   <= count_inc;
                end
                if (last) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else if (bus.start) begin
                state  <= CAPTURE;
                count  <= '0;
                mode_q <= bus.mode;
                busy   <= 1'b1;
                done   <= 1'b0;
            end
        end
    end
    assign bus.storage  = storage;
    assign bus.count    = count;
    assign bus.rd_data  = rd_data;
    assign bus.rd_valid = rd_valid;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.full     = (count == CNT_W'(DEPTH));
endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: directed and randomized checks of adc_capture_buffer against a behavioural model
module tb_adc_capture_buffer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;
    adc_capture_buffer_if #(.SAMPLE_W(12), .DEPTH(10)) a ();
    adc_capture_buffer_if #(.SAMPLE_W(8), .DEPTH(4)) b ();
    adc_capture_buffer #(.SAMPLE_W(12), .DEPTH(10)) dut_a (.clk(clk), .rst(rst), .bus(a));
    adc_capture_buffer #(.SAMPLE_W(8), .DEPTH(4)) dut_b (.clk(clk), .rst(rst), .bus(b));
    logic [11:0] m_store [10];
    logic [11:0] m_rd_data;
    int m_count;
    bit m_busy, m_done, m_mode, m_rd_valid;
    function automatic logic [119:0] m_flat();
        logic [119:0] f;
        for (int i = 0; i < 10; i++) f[i*12 +: 12] = m_store[i];
        return f;
    endfunction
    task automatic model_reset();
        for (int i = 0; i < 10; i++) m_store[i] = '0;
        m_rd_data = '0;
        m_count = 0;
        m_busy = 0;
        m_done = 0;
        m_mode = 0;
        m_rd_valid = 0;
    endtask
    task automatic model_edge();
        int idx;
        idx = int'(a.rd_addr);
        if (a.rd_en) m_rd_data = (idx < 10) ? m_store[idx] : 12'h000;
        m_rd_valid = a.rd_en;
        if (!m_busy) begin
            if (a.start) begin
                m_busy = 1;
                m_done = 0;
                m_count = 0;
                m_mode = a.mode;
            end
        end else begin
            if (a.sample_valid) begin
                for (int i = 9; i > 0; i--) m_store[i] = m_store[i-1];
                m_store[0] = a.sample;
                if (m_count < 10) m_count++;
            end
            if (m_mode ? a.stop : (a.sample_valid && m_count == 10)) begin
                m_busy = 0;
                m_done = 1;
            end
        end
    endtask
    task automatic idle_inputs();
        a.sample = '0; a.sample_valid = 0; a.start = 0; a.stop = 0; a.mode = 0; a.rd_en = 0; a.rd_addr = '0;
        b.sample = '0; b.sample_valid = 0; b.start = 0; b.stop = 0; b.mode = 0; b.rd_en = 0; b.rd_addr = '0;
    endtask
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset();
        idle_inputs();
        model_reset();
        rst = 0;
        #12;
        checks++; if (a.storage !== 120'h0) begin failures++; $display("FAIL reset_storage: got %h want 0", a.storage); end
        checks++; if (a.count !== 4'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", a.count); end
        checks++; if ({a.busy, a.done, a.full, a.rd_valid} !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b want 0000", {a.busy, a.done, a.full, a.rd_valid}); end
        checks++; if (a.rd_data !== 12'h000) begin failures++; $display("FAIL reset_rd_data: got %h want 000", a.rd_data); end
        rst = 1;
        step();
    endtask
    task automatic test_single_shot();
        logic [119:0] snap;
        a.start = 1; a.mode = 0; step(); a.start = 0;
        for (int i = 1; i <= 10; i++) begin
            a.sample_valid = 1; a.sample = 12'(i); step();
            checks++; if (a.done !== 1'(i == 10)) begin failures++; $display("FAIL single_done strobe %0d: got %b want %b", i, a.done, i == 10); end
        end
        a.sample_valid = 0;
        checks++; if (a.count !== 4'd10) begin failures++; $display("FAIL single_count: got %0d want 10", a.count); end
        checks++; if (a.full !== 1'b1) begin failures++; $display("FAIL single_full: got %b want 1", a.full); end
        checks++; if (a.storage[11:0] !== 12'h00A) begin failures++; $display("FAIL single_newest: got %h want 00a", a.storage[11:0]); end
        checks++; if (a.storage[119:108] !== 12'h001) begin failures++; $display("FAIL single_oldest: got %h want 001", a.storage[119:108]); end
        snap = m_flat();
        a.sample_valid = 1; a.sample = 12'h0FF; step(); a.sample_valid = 0;
        checks++; if (a.storage !== snap) begin failures++; $display("FAIL single_extra_strobe: got %h want %h", a.storage, snap); end
    endtask
    task automatic test_read_port();
        logic [11:0] want [3];
        logic [3:0] addrs [3];
        want[0] = 12'h00A; want[1] = 12'h001; want[2] = 12'h000;
        addrs[0] = 4'd0; addrs[1] = 4'd9; addrs[2] = 4'd10;
        a.rd_en = 1;
        for (int i = 0; i < 3; i++) begin
            a.rd_addr = addrs[i]; step();
            checks++; if (a.rd_data !== want[i] || a.rd_valid !== 1'b1) begin failures++; $display("FAIL read_addr%0d: got %h/%b want %h/1", addrs[i], a.rd_data, a.rd_valid, want[i]); end
        end
        a.rd_en = 0; a.rd_addr = 4'd0; step();
        checks++; if (a.rd_valid !== 1'b0 || a.rd_data !== 12'h000) begin failures++; $display("FAIL read_hold: got %h/%b want 000/0", a.rd_data, a.rd_valid); end
    endtask
    task automatic test_rearm();
        logic [119:0] snap;
        snap = a.storage;
        a.start = 1; a.sample_valid = 1; a.sample = 12'h777; step();
        a.start = 0; a.sample_valid = 0;
        checks++; if (a.count !== 4'd0 || a.busy !== 1'b1 || a.done !== 1'b0) begin failures++; $display("FAIL rearm_state: got count=%0d busy=%b done=%b want 0/1/0", a.count, a.busy, a.done); end
        checks++; if (a.storage !== snap) begin failures++; $display("FAIL rearm_storage: got %h want %h", a.storage, snap); end
        for (int i = 0; i < 3; i++) begin
            a.sample_valid = 1; a.sample = 12'($urandom); step();
        end
        a.sample_valid = 0; a.start = 1; a.mode = 1; step(); a.start = 0; a.mode = 0;
        checks++; if (a.count !== 4'd3 || a.busy !== 1'b1) begin failures++; $display("FAIL rearm_start_in_capture: got count=%0d busy=%b want 3/1", a.count, a.busy); end
        a.sample_valid = 1; a.stop = 1; a.sample = 12'($urandom); step(); a.stop = 0;
        checks++; if (a.busy !== 1'b1 || a.count !== 4'd4) begin failures++; $display("FAIL rearm_stop_single: got busy=%b count=%0d want 1/4", a.busy, a.count); end
        for (int i = 0; i < 6; i++) begin
            a.sample = 12'($urandom); step();
        end
        a.sample_valid = 0;
        checks++; if (a.done !== 1'b1 || a.storage !== m_flat()) begin failures++; $display("FAIL rearm_done: got done=%b storage=%h want 1/%h", a.done, a.storage, m_flat()); end
    endtask
    task automatic test_continuous();
        a.start = 1; a.mode = 1; step(); a.start = 0; a.mode = 0;
        for (int i = 1; i <= 13; i++) begin
            a.sample_valid = 1; a.sample = 12'(i); step();
        end
        a.sample_valid = 0;
        checks++; if (a.count !== 4'd10 || a.busy !== 1'b1 || a.full !== 1'b1) begin failures++; $display("FAIL cont_status: got count=%0d busy=%b full=%b want 10/1/1", a.count, a.busy, a.full); end
        checks++; if (a.storage[11:0] !== 12'd13 || a.storage[119:108] !== 12'd4) begin failures++; $display("FAIL cont_window: got newest=%0d oldest=%0d want 13/4", a.storage[11:0], a.storage[119:108]); end
        a.stop = 1; a.sample_valid = 1; a.sample = 12'd14; step(); a.stop = 0; a.sample_valid = 0;
        checks++; if (a.storage[11:0] !== 12'd14 || a.storage[119:108] !== 12'd5) begin failures++; $display("FAIL cont_stop_window: got newest=%0d oldest=%0d want 14/5", a.storage[11:0], a.storage[119:108]); end
        checks++; if (a.done !== 1'b1 || a.busy !== 1'b0) begin failures++; $display("FAIL cont_stop_done: got done=%b busy=%b want 1/0", a.done, a.busy); end
    endtask
    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            a.start = ($urandom_range(0, 19) == 0);
            a.stop = ($urandom_range(0, 14) == 0);
            a.mode = 1'($urandom_range(0, 1));
            a.sample_valid = 1'($urandom_range(0, 1));
            a.sample = 12'($urandom);
            a.rd_en = 1'($urandom_range(0, 1));
            a.rd_addr = 4'($urandom_range(0, 15));
            step();
            checks++; if (a.storage !== m_flat()) begin failures++; $display("FAIL rand_storage cyc %0d: got %h want %h", n, a.storage, m_flat()); end
            checks++; if (a.count !== 4'(m_count) || a.full !== 1'(m_count == 10)) begin failures++; $display("FAIL rand_count cyc %0d: got %0d/%b want %0d", n, a.count, a.full, m_count); end
            checks++; if (a.busy !== m_busy || a.done !== m_done) begin failures++; $display("FAIL rand_state cyc %0d: got busy=%b done=%b want %b/%b", n, a.busy, a.done, m_busy, m_done); end
            checks++; if (a.rd_valid !== m_rd_valid || a.rd_data !== m_rd_data) begin failures++; $display("FAIL rand_read cyc %0d: got %h/%b want %h/%b", n, a.rd_data, a.rd_valid, m_rd_data, m_rd_valid); end
        end
        idle_inputs();
    endtask
    task automatic test_reset_mid_capture();
        if (m_busy) begin a.stop = 1; a.mode = 0; step(); a.stop = 0; end
        while (m_busy) begin a.sample_valid = 1; a.sample = 12'($urandom); step(); end
        a.sample_valid = 0;
        a.start = 1; step(); a.start = 0;
        for (int i = 0; i < 5; i++) begin
            a.sample_valid = 1; a.sample = 12'($urandom_range(1, 4095)); step();
        end
        a.sample_valid = 0;
        #2;
        rst = 0;
        #1;
        checks++; if (a.busy !== 1'b0 || a.count !== 4'd0) begin failures++; $display("FAIL midrst_status: got busy=%b count=%0d want 0/0", a.busy, a.count); end
        checks++; if (a.storage !== 120'h0) begin failures++; $display("FAIL midrst_storage: got %h want 0", a.storage); end
        model_reset();
        #2;
        rst = 1;
        step();
    endtask
    task automatic test_param_sweep();
        logic [7:0] s [4];
        for (int i = 0; i < 4; i++) s[i] = 8'($urandom_range(1, 255));
        b.start = 1; b.mode = 0; step(); b.start = 0;
        for (int i = 0; i < 4; i++) begin
            b.sample_valid = 1; b.sample = s[i]; step();
            checks++; if (b.done !== 1'(i == 3)) begin failures++; $display("FAIL sweep_done strobe %0d: got %b want %b", i + 1, b.done, i == 3); end
        end
        b.sample_valid = 0;
        checks++; if (b.count !== 3'd4 || b.full !== 1'b1) begin failures++; $display("FAIL sweep_count: got %0d/%b want 4/1", b.count, b.full); end
        checks++; if (b.storage !== {s[0], s[1], s[2], s[3]}) begin failures++; $display("FAIL sweep_storage: got %h want %h", b.storage, {s[0], s[1], s[2], s[3]}); end
        b.rd_en = 1; b.rd_addr = 3'd0; step();
        checks++; if (b.rd_data !== s[3]) begin failures++; $display("FAIL sweep_read0: got %h want %h", b.rd_data, s[3]); end
        b.rd_addr = 3'd3; step();
        checks++; if (b.rd_data !== s[0]) begin failures++; $display("FAIL sweep_read3: got %h want %h", b.rd_data, s[0]); end
        b.rd_addr = 3'd4; step();
        checks++; if (b.rd_data !== 8'h00 || b.rd_valid !== 1'b1) begin failures++; $display("FAIL sweep_read4: got %h/%b want 00/1", b.rd_data, b.rd_valid); end
        b.rd_en = 0;
    endtask
    initial begin
        test_reset();
        test_single_shot();
        test_read_port();
        test_rearm();
        test_continuous();
        test_random();
        test_reset_mid_capture();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_capture_buffer.md
Name: adc_capture_buffer

Overview:
- Parametrised capture buffer that sits behind the 12-bit SPI ADC reader.
- Shifts a configurable number of ADC samples into a flat shift-register store, newest sample at the bottom.
- Adds start/stop control, single-shot and continuous (rolling-window) modes, a done/full status, and a registered random-access read port.
- Downstream logic, such as the twinning comparator, can read samples individually or use the flat vector.

Parameters:
SAMPLE_W, 12, width of one ADC sample in bits (legal range 1..32).
DEPTH, 10, number of samples held (legal range 2..64); localparam CNT_W = $clog2(DEPTH+1).

Ports:
clk  input  1  50 MHz system clock; all state changes on its rising edge.
rst  input  1  asynchronous active-low reset.
sample  input  SAMPLE_W  conversion result from the ADC reader.
sample_valid  input  1  one-cycle strobe; sample is valid this cycle.
start  input  1  one-cycle pulse; arms a new capture.
stop  input  1  one-cycle pulse; ends a continuous capture.
mode  input  1  0 = single-shot, 1 = continuous; latched on an accepted start.
rd_en  input  1  read request.
rd_addr  input  CNT_W  sample index; 0 = newest, DEPTH-1 = oldest.
rd_data  output  SAMPLE_W  registered read result.
rd_valid  output  1  high for the one cycle after rd_en.
storage  output  DEPTH*SAMPLE_W  flat store; bits [SAMPLE_W-1:0] hold the newest sample.
count  output  CNT_W  samples captured since the last start; saturates at DEPTH.
busy  output  1  high in CAPTURE.
done  output  1  high in DONE.
full  output  1  count == DEPTH.

Behaviour:
- Reset (rst low, asynchronous): state = IDLE; storage, count, rd_data, rd_valid, busy, done, full and the latched mode all go to 0.
- Reset mid-capture: abandons the capture and clears the whole store, not only the low word.
- States: IDLE, CAPTURE, DONE. busy = (state == CAPTURE) and done = (state == DONE), both registered.
- IDLE or DONE with start=1:
  - go to CAPTURE; count <= 0; latch mode.
  - storage is NOT cleared.
  - A sample_valid in the same cycle is ignored.
- CAPTURE with sample_valid=1:
  - storage <= {storage[(DEPTH-1)*SAMPLE_W-1:0], sample}; the oldest sample is discarded.
  - count <= count+1, saturating at DEPTH.
- CAPTURE in single-shot mode: when the accepted sample makes count == DEPTH, go to DONE in the same edge. stop is ignored in this mode.
- CAPTURE in continuous mode:
  - Keep shifting indefinitely; full rises once count reaches DEPTH.
  - stop=1 goes to DONE.
  - stop and sample_valid in the same cycle: the sample is accepted, then the block goes to DONE.
- start while in CAPTURE: ignored.
- sample_valid in IDLE or DONE: ignored; storage and count unchanged.
- mode changes outside an accepted start have no effect on a capture in progress.
- Read port:
  - rd_en=1 at edge N gives rd_data = storage word rd_addr and rd_valid=1 after edge N; latency is 1 cycle.
  - rd_addr >= DEPTH returns 0.
  - Reads are legal in any state. If a read and a shift hit the same edge, the read returns pre-shift data.
  - rd_data holds its value when rd_en=0.
- count width is CNT_W and never wraps.

Test Plan:
- Single-shot, DEPTH=10, SAMPLE_W=12: reset, start(mode=0), 10 strobes with samples 0x001..0x00A. Required: done=1 on the edge of the 10th strobe, count=10, full=1; storage[11:0]=0x00A, storage[119:108]=0x001. An 11th strobe leaves storage unchanged.
- Continuous rolling window: start(mode=1), 13 strobes with samples 1..13. Required: count=10, busy=1, newest=13, oldest=4. Then stop and sample_valid(14) in the same cycle: newest=14, oldest=5, done=1.
- Read port: after the first test, rd_en with rd_addr=0, 9, 10 on consecutive cycles. Required, one cycle later each: rd_data=0x00A, 0x001, 0x000, with rd_valid high each cycle.
- Re-arm and ignores: in DONE, pulse start together with sample_valid. Required: count=0, storage unchanged, that sample ignored. A start during CAPTURE does not reset count.
- Reset mid-capture: assert rst low after 5 strobes. Required: busy, count and every storage bit read 0 immediately, without waiting for a clock edge.
- Parameter sweep: SAMPLE_W=8, DEPTH=4, repeating the first test. Required: done after 4 strobes, storage width 32, rd_addr=4 returns 0.
